// File: rtl/core_pkg.sv
// Shared core types: writeback result source, load funct3 codes and the
// writeback FSM state encoding.
package core_pkg;

    // Selects what the writeback stage sends to the register file.
    // Code 3 is reserved and is treated like RES_ALU.
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_RSVD = 2'd3
    } result_src_e;

    // Load width/sign codes carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM: IDLE accepts instructions, WAIT_LOAD holds a load
    // until the data-memory read response arrives.
    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the byte/halfword addressed by
// the low address bits out of an aligned 32-bit word and extends it.
// Kept stand-alone so the LSU can reuse it.
module load_extend
    import core_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/halfword and apply sign or zero extension.
    always_comb begin
        w_byte  = 8'h00;
        w_half  = 16'h0000;
        o_value = i_rdata;
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_value = {24'h000000, w_byte};
            F3_LH:   o_value = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_value = {16'h0000, w_half};
            default: o_value = i_rdata;  // LW and unused codes: full word
        endcase
    end

endmodule

// File: rtl/stage_writeback.sv
// Final pipeline stage: completes loads (waiting on the read response when
// needed), selects the writeback value, drives the register-file write
// port and counts retired instructions.
//
// Handshake: an instruction is offered while mem_valid=1. It is accepted
// in any cycle where wb_stall=0; while wb_stall=1 upstream keeps every
// mem_* input stable. dmem_rvalid is a one-cycle data strobe with no
// backpressure and is only consumed while a load is being completed.
module stage_writeback
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_instr_addr_plus,
    input  logic [1:0]  mem_result_src,
    input  logic        mem_wr_enable,
    input  logic [2:0]  mem_funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_stall,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic        wb_wr_enable,
    output logic        wb_retire,
    output logic [63:0] wb_instret
);

    wb_state_e   r_state;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    logic        r_wr_enable;
    logic        r_retire;
    logic [63:0] r_instret;

    result_src_e w_src;
    logic        w_is_load;
    logic        w_complete;
    logic        w_enter_wait;
    logic [31:0] w_load_value;
    logic [31:0] w_sel_result;

    load_extend u_load_extend (
        .i_rdata  (dmem_rdata),
        .i_offset (mem_alu_result[1:0]),
        .i_funct3 (mem_funct3),
        .o_value  (w_load_value)
    );

    // Decide completion/stall from state and current inputs only; the
    // registered wb_* outputs never feed back into the stall path.
    always_comb begin
        w_src        = result_src_e'(mem_result_src);
        w_is_load    = (w_src == RES_LOAD);
        w_complete   = 1'b0;
        w_enter_wait = 1'b0;
        wb_stall     = 1'b0;
        if (r_state == WB_IDLE) begin
            if (mem_valid) begin
                w_complete   = !w_is_load || dmem_rvalid;
                w_enter_wait = w_is_load && !dmem_rvalid;
                wb_stall     = w_is_load && !dmem_rvalid;
            end
        end else begin
            w_complete = dmem_rvalid;
            wb_stall   = !dmem_rvalid;
        end
    end

    // Writeback value mux; the reserved source code falls back to the ALU.
    always_comb begin
        w_sel_result = mem_alu_result;
        case (w_src)
            RES_LOAD: w_sel_result = w_load_value;
            RES_PC4:  w_sel_result = mem_instr_addr_plus;
            default:  w_sel_result = mem_alu_result;
        endcase
    end

    // FSM with registered writeback outputs and the retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WB_IDLE;
            r_rd        <= 5'd0;
            r_result    <= 32'd0;
            r_wr_enable <= 1'b0;
            r_retire    <= 1'b0;
            r_instret   <= 64'd0;
        end else begin
            r_wr_enable <= 1'b0;
            r_retire    <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (w_enter_wait) begin
                        r_state <= WB_WAIT_LOAD;
                    end
                end
                default: begin
                    if (dmem_rvalid) begin
                        r_state <= WB_IDLE;
                    end
                end
            endcase
            if (w_complete) begin
                r_rd        <= mem_rd;
                r_result    <= w_sel_result;
                r_wr_enable <= mem_wr_enable && (mem_rd != 5'd0);
                r_retire    <= 1'b1;
                r_instret   <= r_instret + 64'd1;
            end
        end
    end

    assign wb_rd        = r_rd;
    assign wb_result    = r_result;
    assign wb_wr_enable = r_wr_enable;
    assign wb_retire    = r_retire;
    assign wb_instret   = r_instret;

endmodule

// File: tb/tb_stage_writeback.sv
// Bench for stage_writeback: directed scenarios plus a randomized stream
// checked against a behavioural model of the writeback rules.
module tb_stage_writeback;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_instr_addr_plus;
  logic [1:0]  mem_result_src;
  logic        mem_wr_enable;
  logic [2:0]  mem_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_stall;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_wr_enable;
  logic        wb_retire;
  logic [63:0] wb_instret;

  int n_cmp;
  int n_fail;
  logic [63:0] exp_instret;
  logic [37:0] exp_q[$];

  stage_writeback dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_valid           (mem_valid),
    .mem_rd              (mem_rd),
    .mem_alu_result      (mem_alu_result),
    .mem_instr_addr_plus (mem_instr_addr_plus),
    .mem_result_src      (mem_result_src),
    .mem_wr_enable       (mem_wr_enable),
    .mem_funct3          (mem_funct3),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata),
    .wb_stall            (wb_stall),
    .wb_rd               (wb_rd),
    .wb_result           (wb_result),
    .wb_wr_enable        (wb_wr_enable),
    .wb_retire           (wb_retire),
    .wb_instret          (wb_instret)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Load value from the architectural definition: shift the word so the
  // addressed item is at bit 0, then extend by width and signedness.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = rdata >> (8 * int'(off));
    hsh = rdata >> (16 * int'(off[1]));
    case (f3)
      3'b000:  return 32'($signed(bsh[7:0]));
      3'b100:  return bsh & 32'hFF;
      3'b001:  return 32'($signed(hsh[15:0]));
      3'b101:  return hsh & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] alu,
                                             input logic [31:0] pc4, input logic [31:0] rdata,
                                             input logic [2:0] f3);
    if (src == 2'd1) return ref_load(rdata, alu[1:0], f3);
    if (src == 2'd2) return pc4;
    return alu;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. Offers one instruction; for loads the response
  // comes lat cycles after acceptance. Returns at posedge+1 after the
  // completing edge, with stall cycles and premature write pulses counted.
  task automatic drive_instr(input logic [1:0] src, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] pc4,
                             input logic wr, input logic [2:0] f3,
                             input logic [31:0] rdata, input int lat,
                             output int stalls, output int early_we);
    stalls = 0;
    early_we = 0;
    mem_valid = 1'b1;
    mem_rd = rd;
    mem_alu_result = alu;
    mem_instr_addr_plus = pc4;
    mem_result_src = src;
    mem_wr_enable = wr;
    mem_funct3 = f3;
    for (int k = 0; k <= lat; k++) begin
      dmem_rvalid = (src == 2'd1) && (k == lat);
      dmem_rdata = dmem_rvalid ? rdata : $urandom;
      #3;
      if (wb_stall) stalls++;
      @(posedge clk);
      #1;
      if (k < lat && wb_wr_enable) early_we++;
    end
    mem_valid = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    mem_valid = 1'b0;
    mem_rd = '0;
    mem_alu_result = '0;
    mem_instr_addr_plus = '0;
    mem_result_src = '0;
    mem_wr_enable = 1'b0;
    mem_funct3 = '0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    exp_instret = '0;
    #23;
    n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", wb_stall); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    n_cmp++; if (wb_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", wb_result); end
    n_cmp++; if (wb_wr_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", wb_wr_enable); end
    n_cmp++; if (wb_retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got=%b exp=0", wb_retire); end
    n_cmp++; if (wb_instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", wb_instret); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    int st, ew;
    drive_instr(2'd0, 5'd5, 32'h1234, 32'h0, 1'b1, 3'b010, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got=%0d exp=5", wb_rd); end
    n_cmp++; if (wb_result !== 32'h1234) begin n_fail++; $display("FAIL alu_result got=%h exp=1234", wb_result); end
    n_cmp++; if (wb_wr_enable !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%b exp=1", wb_wr_enable); end
    n_cmp++; if (wb_retire !== 1'b1) begin n_fail++; $display("FAIL alu_retire got=%b exp=1", wb_retire); end
    n_cmp++; if (wb_instret !== exp_instret) begin n_fail++; $display("FAIL alu_instret got=%0d exp=%0d", wb_instret, exp_instret); end
    n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL alu_stall got=%0d exp=0", st); end
    @(posedge clk);
    #1;
    n_cmp++; if (wb_wr_enable !== 1'b0) begin n_fail++; $display("FAIL alu_we_pulse got=%b exp=0", wb_wr_enable); end
    n_cmp++; if (wb_retire !== 1'b0) begin n_fail++; $display("FAIL alu_retire_pulse got=%b exp=0", wb_retire); end
  endtask

  task automatic test_load_latency();
    int st, ew;
    drive_instr(2'd1, 5'd9, 32'h0000_1003, 32'h0, 1'b1, 3'b000, 32'h80FF_FF00, 3, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (st !== 3) begin n_fail++; $display("FAIL lat_stall_cycles got=%0d exp=3", st); end
    n_cmp++; if (ew !== 0) begin n_fail++; $display("FAIL lat_early_we got=%0d exp=0", ew); end
    n_cmp++; if (wb_result !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lat_result got=%h exp=ffffff80", wb_result); end
    n_cmp++; if (wb_wr_enable !== 1'b1) begin n_fail++; $display("FAIL lat_we got=%b exp=1", wb_wr_enable); end
    n_cmp++; if (wb_instret !== exp_instret) begin n_fail++; $display("FAIL lat_instret got=%0d exp=%0d", wb_instret, exp_instret); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL lat_stall_after got=%b exp=0", wb_stall); end
    @(posedge clk);
    #1;
    n_cmp++; if (wb_wr_enable !== 1'b0) begin n_fail++; $display("FAIL lat_single_write got=%b exp=0", wb_wr_enable); end
  endtask

  task automatic test_extend_sweep();
    logic [2:0]  f3_t[5]  = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [1:0]  off_t[5] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [31:0] exp_t[5] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7F02, 32'hFFFF_FF80};
    int st, ew;
    for (int i = 0; i < 5; i++) begin
      drive_instr(2'd1, 5'd3, {30'h100, off_t[i]}, 32'h0, 1'b1, f3_t[i], 32'h8001_7F02, 0, st, ew);
      exp_instret = exp_instret + 64'd1;
      n_cmp++;
      if (wb_result !== exp_t[i] || wb_result !== ref_load(32'h8001_7F02, off_t[i], f3_t[i])) begin
        n_fail++;
        $display("FAIL ext_sweep_%0d got=%h exp=%h", i, wb_result, exp_t[i]);
      end
      n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL ext_sweep_stall_%0d got=%0d exp=0", i, st); end
    end
  endtask

  task automatic test_pc4();
    int st, ew;
    drive_instr(2'd2, 5'd1, 32'hDEAD_BEEF, 32'h100, 1'b1, 3'b000, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_result !== 32'h100) begin n_fail++; $display("FAIL pc4_result got=%h exp=100", wb_result); end
    n_cmp++; if (wb_rd !== 5'd1) begin n_fail++; $display("FAIL pc4_rd got=%0d exp=1", wb_rd); end
    drive_instr(2'd3, 5'd2, 32'h0000_0ABC, 32'h200, 1'b1, 3'b000, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_result !== 32'h0ABC) begin n_fail++; $display("FAIL rsvd_src_result got=%h exp=abc", wb_result); end
  endtask

  task automatic test_rd0_bubble();
    int st, ew;
    drive_instr(2'd0, 5'd0, 32'h5555, 32'h0, 1'b1, 3'b000, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_wr_enable !== 1'b0) begin n_fail++; $display("FAIL rd0_we got=%b exp=0", wb_wr_enable); end
    n_cmp++; if (wb_retire !== 1'b1) begin n_fail++; $display("FAIL rd0_retire got=%b exp=1", wb_retire); end
    n_cmp++; if (wb_instret !== exp_instret) begin n_fail++; $display("FAIL rd0_instret got=%0d exp=%0d", wb_instret, exp_instret); end
    // bubble carrying a load source with a stray read response
    mem_valid = 1'b0;
    mem_rd = 5'd17;
    mem_result_src = 2'd1;
    mem_alu_result = 32'h9999;
    mem_wr_enable = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    #3;
    n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL bubble_stall got=%b exp=0", wb_stall); end
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    n_cmp++; if (wb_wr_enable !== 1'b0) begin n_fail++; $display("FAIL bubble_we got=%b exp=0", wb_wr_enable); end
    n_cmp++; if (wb_retire !== 1'b0) begin n_fail++; $display("FAIL bubble_retire got=%b exp=0", wb_retire); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL bubble_rd_hold got=%0d exp=0", wb_rd); end
    n_cmp++; if (wb_result !== 32'h5555) begin n_fail++; $display("FAIL bubble_result_hold got=%h exp=5555", wb_result); end
    n_cmp++; if (wb_instret !== exp_instret) begin n_fail++; $display("FAIL bubble_instret got=%0d exp=%0d", wb_instret, exp_instret); end
    // a follow-on instruction must see no stray pending load
    drive_instr(2'd0, 5'd4, 32'h4444, 32'h0, 1'b1, 3'b000, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_result !== 32'h4444 || st !== 0) begin n_fail++; $display("FAIL after_bubble got=%h/%0d exp=4444/0", wb_result, st); end
  endtask

  task automatic test_reset_wait();
    mem_valid = 1'b1;
    mem_rd = 5'd7;
    mem_result_src = 2'd1;
    mem_wr_enable = 1'b1;
    mem_funct3 = 3'b010;
    mem_alu_result = 32'h40;
    dmem_rvalid = 1'b0;
    #3;
    n_cmp++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall got=%b exp=1", wb_stall); end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_cmp++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall_held got=%b exp=1", wb_stall); end
    mem_valid = 1'b0;
    rst_n = 1'b0;
    exp_instret = '0;
    #2;
    n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL rstwait_stall got=%b exp=0", wb_stall); end
    n_cmp++; if (wb_rd !== 5'd0 || wb_result !== 32'd0) begin n_fail++; $display("FAIL rstwait_data got=%0d/%h exp=0/0", wb_rd, wb_result); end
    n_cmp++; if (wb_wr_enable !== 1'b0 || wb_retire !== 1'b0) begin n_fail++; $display("FAIL rstwait_pulses got=%b%b exp=00", wb_wr_enable, wb_retire); end
    n_cmp++; if (wb_instret !== 64'd0) begin n_fail++; $display("FAIL rstwait_instret got=%0d exp=0", wb_instret); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    n_cmp++; if (wb_wr_enable !== 1'b0 || wb_retire !== 1'b0) begin n_fail++; $display("FAIL rstwait_late_rvalid got=%b%b exp=00", wb_wr_enable, wb_retire); end
    n_cmp++; if (wb_instret !== 64'd0) begin n_fail++; $display("FAIL rstwait_late_instret got=%0d exp=0", wb_instret); end
  endtask

  task automatic test_wrap();
    int st, ew;
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    release dut.r_instret;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    drive_instr(2'd0, 5'd6, 32'h66, 32'h0, 1'b1, 3'b000, 32'h0, 0, st, ew);
    exp_instret = exp_instret + 64'd1;
    n_cmp++; if (wb_instret !== exp_instret) begin n_fail++; $display("FAIL wrap_instret got=%h exp=%h", wb_instret, exp_instret); end
    n_cmp++; if (wb_retire !== 1'b1) begin n_fail++; $display("FAIL wrap_retire got=%b exp=1", wb_retire); end
  endtask

  task automatic test_back_to_back();
    int st, ew;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, rdata;
    logic        wr;
    logic [2:0]  f3;
    int          lat;
    logic [37:0] exp_v;
    for (int i = 0; i < 60; i++) begin
      src = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      alu = $urandom;
      pc4 = $urandom;
      rdata = $urandom;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      lat = (src == 2'd1) ? int'($urandom_range(0, 3)) : 0;
      exp_q.push_back({rd, wr && (rd != 5'd0), ref_result(src, alu, pc4, rdata, f3)});
      drive_instr(src, rd, alu, pc4, wr, f3, rdata, lat, st, ew);
      exp_instret = exp_instret + 64'd1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if ({wb_rd, wb_wr_enable, wb_result} !== exp_v) begin
        n_fail++;
        $display("FAIL rand_%0d_data got=%0d/%b/%h exp=%0d/%b/%h", i, wb_rd, wb_wr_enable, wb_result,
                 exp_v[37:33], exp_v[32], exp_v[31:0]);
      end
      n_cmp++;
      if (st !== lat || ew !== 0 || wb_retire !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_%0d_timing got=stall%0d/early%0d/ret%b exp=stall%0d/early0/ret1", i, st, ew, wb_retire, lat);
      end
      n_cmp++;
      if (wb_instret !== exp_instret) begin
        n_fail++;
        $display("FAIL rand_%0d_instret got=%0d exp=%0d", i, wb_instret, exp_instret);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_load_latency();
    test_extend_sweep();
    test_pc4();
    test_rd0_bubble();
    test_reset_wait();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout reached=1 expected=0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $finish;
  end

endmodule

// File: doc/stage_writeback.md
# stage_writeback

Final pipeline stage of the core: consumes the memory-stage register outputs, completes outstanding loads by waiting on the data-memory read response, and drives the register-file write port. It sign- or zero-extends load data, selects the writeback result by result source, and stalls upstream stages while a load response is pending. It also counts retired instructions for the CSR unit.

## Interface
- No parameters. Data width is fixed at 32; the counter is 64 bits.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  the memory stage holds a real instruction (0 = bubble).
- mem_rd  in  5  destination register.
- mem_alu_result  in  32  ALU result / load effective address.
- mem_instr_addr_plus  in  32  PC+4.
- mem_result_src  in  2  result select, `result_src_e`.
- mem_wr_enable  in  1  register-file write request.
- mem_funct3  in  3  load width/sign code.
- dmem_rvalid  in  1  read data valid this cycle.
- dmem_rdata  in  32  aligned 32-bit read word.
- wb_stall  out  1  combinational; freezes the fetch, decode, execute and memory stages.
- wb_rd  out  5  register-file write address.
- wb_result  out  32  register-file write data.
- wb_wr_enable  out  1  register-file write strobe, one cycle per instruction.
- wb_retire  out  1  one-cycle pulse per completed instruction.
- wb_instret  out  64  retired-instruction count.

## Operation
- `result_src_e` encodings:
  - RES_ALU = 0: mem_alu_result.
  - RES_LOAD = 1: extended load data.
  - RES_PC4 = 2: mem_instr_addr_plus.
  - 3 is reserved and treated as RES_ALU.
- States:
  - IDLE (reset state).
  - WAIT_LOAD.
- IDLE, when mem_valid=1 and source is not LOAD:
  - Register the selected result.
  - wb_wr_enable <= mem_wr_enable && mem_rd!=0.
  - Pulse wb_retire.
- IDLE, when mem_valid=1, source is LOAD and dmem_rvalid=1: complete the load in the same cycle. No stall.
- IDLE, when mem_valid=1, source is LOAD and dmem_rvalid=0:
  - wb_stall=1 combinationally.
  - Next state is WAIT_LOAD.
  - Outputs are not updated.
- WAIT_LOAD:
  - wb_stall = !dmem_rvalid.
  - Upstream holds all mem_* inputs stable.
  - On dmem_rvalid=1: complete the load and return to IDLE.
- Completing a load: take the byte offset from mem_alu_result[1:0] and select from dmem_rdata.
  - funct3 000 LB: byte at offset, sign-extended.
  - funct3 100 LBU: byte at offset, zero-extended.
  - funct3 001 LH: halfword selected by bit [1], sign-extended.
  - funct3 101 LHU: halfword selected by bit [1], zero-extended.
  - funct3 010 LW and all other codes: full word.
- rd=0 never asserts wb_wr_enable, but the instruction still retires.
- mem_valid=0: no write, no retire. wb_rd and wb_result hold their last values.
- dmem_rvalid when no load is pending: ignored.
- wb_instret increments by 1 on every wb_retire and wraps from 2^64-1 to 0.

## Timing
- Reset: state=IDLE and wb_stall=0. All of the following are 0:
  - wb_rd
  - wb_result
  - wb_wr_enable
  - wb_retire
  - wb_instret
- Reset mid-WAIT_LOAD: the load is dropped with no write and no retire.
- Latency: non-load, or load with response in the accept cycle N → outputs valid after the edge ending N (N+1).
- Load whose response arrives in cycle N+k → wb_stall high for cycles N..N+k-1, outputs valid at N+k+1.
- wb_wr_enable and wb_retire are single-cycle pulses. Back-to-back instructions give consecutive pulses.
- wb_stall has no dependence on wb_* outputs (no combinational loop). It depends only on state, mem_valid, mem_result_src and dmem_rvalid.

## Structure
- `core_pkg` holds:
  - `result_src_e`.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - The `wb_state_e` enum.
- One sub-module, `load_extend`: combinational rdata/offset/funct3 → 32-bit value, reusable by the LSU.
- Remaining content: FSM, output registers, instret counter.

## Test plan
- ALU op: mem_valid=1, src=ALU, rd=5, alu=0x1234, wr=1 → next cycle wb_rd=5, wb_result=0x1234, wb_wr_enable=1, wb_retire=1, instret=1.
- Load with 3-cycle latency:
  - Stimulus: LB, addr=0x...3, rdata=0x80FF_FF00, rvalid asserted 3 cycles after accept.
  - Required: wb_stall high for 3 cycles, then wb_result=0xFFFF_FF80, with exactly one write.
- Extension sweep, rdata=0x8001_7F02:
  - LBU offset 1 → 0x7F.
  - LH offset 2 → 0xFFFF_8001.
  - LHU offset 2 → 0x8001.
  - LW → 0x8001_7F02.
- JAL-style instruction: src=PC4, pc+4=0x100, rd=1 → wb_result=0x100.
- rd=0 then a bubble:
  - rd=0 with wr=1 → wb_wr_enable=0, wb_retire=1.
  - mem_valid=0 → no pulses.
  - A stray dmem_rvalid in IDLE → no effect.
- rst_n low during WAIT_LOAD → all outputs 0, wb_stall=0; a later rvalid produces no write. Preload instret=2^64-1, retire once → 0.
